mult_acc: RTL and testbench

- Downstream consumer of the combinational `mult_n` array multiplier.
- Accepts a stream of 2N-bit products qualified by `p_valid` and accumulates a fixed number of terms (TERMS) into a wide register. Saturates on overflow.
- Signals completion so a display or control stage can read the dot-product style result.
- Sits between `mult_n`'s `p` output and the HEX/LED readout logic.

---
 rtl/mult_acc_if.sv | 26 ++
 rtl/mult_acc.sv | 75 +++++++
 tb/tb_mult_acc.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mult_acc_if.sv
// rtl/mult_acc_if.sv - control, product and result bundle between mult_n, mult_acc and the readout
interface mult_acc_if #(
  parameter int N     = 8,
  parameter int TERMS = 4,
  parameter int ACC_W = 20
);
  logic                           clear;
  logic                           start;
  logic [2*N-1:0]                 p;
  logic                           p_valid;
  logic [ACC_W-1:0]               acc;
  logic [$clog2(TERMS+1)-1:0]     count;
  logic                           busy;
  logic                           done;
  logic                           overflow;

  modport master (
    output clear, start, p, p_valid,
    input  acc, count, busy, done, overflow
  );

  modport slave (
    input  clear, start, p, p_valid,
    output acc, count, busy, done, overflow
  );
endinterface

// File: rtl/mult_acc.sv
// rtl/mult_acc.sv - saturating accumulator of TERMS unsigned products per run
module mult_acc #(
  parameter int N     = 8,
  parameter int TERMS = 4,
  parameter int ACC_W = 20
) (
  input  logic       clk,
  input  logic       reset,
  mult_acc_if.slave  bus
);
  localparam int CW = $clog2(TERMS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc_q, acc_nx;
  logic [CW-1:0]    cnt_q, cnt_nx;
  logic             ovf_q, ovf_nx;
  logic [ACC_W:0]   sum;

  // Carry-out of the extra top bit is the saturation condition
  assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - 2*N){1'b0}}, bus.p};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nx;
      acc_q <= acc_nx;
      cnt_q <= cnt_nx;
      ovf_q <= ovf_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc_q;
    cnt_nx   = cnt_q;
    ovf_nx   = ovf_q;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          acc_nx   = '0;
          cnt_nx   = '0;
          ovf_nx   = 1'b0;
          state_nx = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.p_valid) begin
          acc_nx = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
          ovf_nx = ovf_q | sum[ACC_W];
          cnt_nx = cnt_q + 1'b1;
          if (cnt_q == CW'(TERMS - 1)) state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (bus.clear) begin
      state_nx = IDLE;
      acc_nx   = '0;
      cnt_nx   = '0;
      ovf_nx   = 1'b0;
    end
  end

  assign bus.acc      = acc_q;
  assign bus.count    = cnt_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state == ACCUM);
  assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_mult_acc.sv
// tb/tb_mult_acc.sv - directed and random checks of two mult_acc widths against a sum-and-clamp model
module tb_mult_acc;
  logic        clk = 1'b0;
  logic        reset, clear, start, p_valid;
  logic [15:0] p;

  int nvec = 0;
  int nfail = 0;
  bit checking = 1'b0;

  mult_acc_if #(.N(8), .TERMS(4), .ACC_W(20)) if0 ();
  mult_acc_if #(.N(8), .TERMS(4), .ACC_W(17)) if1 ();

  assign if0.clear = clear;   assign if1.clear = clear;
  assign if0.start = start;   assign if1.start = start;
  assign if0.p = p;           assign if1.p = p;
  assign if0.p_valid = p_valid; assign if1.p_valid = p_valid;

  mult_acc #(.N(8), .TERMS(4), .ACC_W(20)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  mult_acc #(.N(8), .TERMS(4), .ACC_W(17)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  always #5 clk = ~clk;

  // Model: running flag/terms taken, plus per-width clamped sum and sticky flag
  longint m_acc [2];
  bit     m_ovf [2];
  int     m_cnt = 0;
  bit     m_running = 0, m_finished = 0;
  longint maxv [2] = '{(64'd1 << 20) - 1, (64'd1 << 17) - 1};

  task automatic model_step();
    if (reset || clear) begin
      m_running = 0; m_finished = 0; m_cnt = 0;
      for (int i = 0; i < 2; i++) begin m_acc[i] = 0; m_ovf[i] = 0; end
    end else if (start && !m_running) begin
      m_running = 1; m_finished = 0; m_cnt = 0;
      for (int i = 0; i < 2; i++) begin m_acc[i] = 0; m_ovf[i] = 0; end
    end else if (m_running && p_valid) begin
      for (int i = 0; i < 2; i++) begin
        if (m_acc[i] + longint'(p) > maxv[i]) begin
          m_acc[i] = maxv[i]; m_ovf[i] = 1;
        end else m_acc[i] = m_acc[i] + longint'(p);
      end
      m_cnt++;
      if (m_cnt == 4) begin m_running = 0; m_finished = 1; end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("acc0", 64'(if0.acc), 64'(m_acc[0]));
      chk("acc1", 64'(if1.acc), 64'(m_acc[1]));
      chk("ovf0", 64'(if0.overflow), 64'(m_ovf[0]));
      chk("ovf1", 64'(if1.overflow), 64'(m_ovf[1]));
      chk("count0", 64'(if0.count), 64'(m_cnt));
      chk("count1", 64'(if1.count), 64'(m_cnt));
      chk("busy", {62'd0, if1.busy, if0.busy}, {62'd0, m_running, m_running});
      chk("done", {62'd0, if1.done, if0.done}, {62'd0, m_finished, m_finished});
    end
  end

  task automatic cyc(input bit rs, input bit cl, input bit st, input bit pv, input logic [15:0] pp);
    reset = rs; clear = cl; start = st; p_valid = pv; p = pp;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic term(input logic [15:0] pp);
    cyc(0, 0, 0, 1, pp);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 16'd9999);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    checking = 1'b1;
    cyc(1, 0, 0, 0, 0);
    chk("reset_acc", 64'(if0.acc), 0);
    chk("reset_done", 64'(if0.done), 0);

    // Basic back-to-back run
    cyc(0, 0, 1, 0, 0);
    term(16'd15);    chk("basic_acc1", 64'(if0.acc), 15);
    term(16'd100);   chk("basic_acc2", 64'(if0.acc), 115);
    term(16'd65025); chk("basic_acc3", 64'(if0.acc), 65140);
    chk("basic_busy", 64'(if0.busy), 1);
    term(16'd0);     chk("basic_acc4", 64'(if0.acc), 65140);
    chk("basic_cnt", 64'(if0.count), 4);
    chk("basic_done", 64'(if0.done), 1);
    chk("basic_busy_end", 64'(if0.busy), 0);
    chk("basic_ovf", 64'(if0.overflow), 0);

    // Gapped run
    cyc(0, 0, 1, 0, 0);
    term(16'd15); gap(3); chk("gap_hold", 64'(if0.acc), 15);
    term(16'd100); gap(3); term(16'd65025); gap(3);
    chk("gap_notdone", 64'(if0.done), 0);
    term(16'd0);
    chk("gap_acc", 64'(if0.acc), 65140);
    chk("gap_done", 64'(if0.done), 1);

    // Saturation on the 17-bit instance
    cyc(0, 0, 1, 0, 0);
    term(16'd65025); chk("sat_acc1", 64'(if1.acc), 65025);
    term(16'd65025); chk("sat_acc2", 64'(if1.acc), 130050);
    chk("sat_ovf2", 64'(if1.overflow), 0);
    term(16'd65025); chk("sat_acc3", 64'(if1.acc), 131071);
    chk("sat_ovf3", 64'(if1.overflow), 1);
    term(16'd1);     chk("sat_acc4", 64'(if1.acc), 131071);
    chk("sat_done", 64'(if1.done), 1);
    chk("wide_acc4", 64'(if0.acc), 195076);

    // Restart from DONE, with a term offered alongside start
    cyc(0, 0, 1, 1, 16'd7);
    chk("rst_acc", 64'(if1.acc), 0);
    chk("rst_ovf", 64'(if1.overflow), 0);
    repeat (4) term(16'd2);
    chk("rst_final", 64'(if1.acc), 8);
    chk("rst_cnt", 64'(if1.count), 4);

    // Clear and reset mid-run
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 1, 0, 0);
      term(16'd15); term(16'd100);
      chk("mid_acc", 64'(if0.acc), 115);
      cyc(k == 1, k == 0, 0, 0, 0);
      chk("mid_cleared_acc", 64'(if0.acc), 0);
      chk("mid_cleared_cnt", 64'(if0.count), 0);
      chk("mid_cleared_busy", 64'(if0.busy), 0);
      term(16'd50);
      chk("idle_ignore", 64'(if0.acc), 0);
    end

    // start during ACCUM is ignored
    cyc(0, 0, 1, 0, 0);
    term(16'd15);
    cyc(0, 0, 1, 0, 0);
    chk("st_accum_acc", 64'(if0.acc), 15);
    chk("st_accum_cnt", 64'(if0.count), 1);
    term(16'd1); term(16'd1); term(16'd1);
    chk("st_accum_final", 64'(if0.acc), 18);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, rp);
    end

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
